// File: rtl/relu_maxpool_2x2.sv
// ReLU + arithmetic-shift requantize + unsigned saturation, followed by 2x2/stride-2
// max pooling over a raster stream, using a half-width row buffer.
module relu_maxpool_2x2 #(
    parameter int unsigned D_BW  = 19,
    parameter int unsigned O_BW  = 8,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic signed [D_BW-1:0] i_data,
    output logic                   o_valid,
    output logic [O_BW-1:0]        o_data,
    output logic                   o_frame_done
);

    localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned BW   = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam int unsigned RB_N = 1 << BW;

    // Stage 1 datapath: clamp negatives, requantize, saturate to O_BW
    logic [D_BW-1:0] relu_c;
    logic [D_BW-1:0] shifted_c;
    logic [O_BW-1:0] sat_c;

    always_comb begin
        relu_c    = i_data[D_BW-1] ? '0 : D_BW'(i_data);
        shifted_c = relu_c >> SHIFT;
        sat_c     = (|shifted_c[D_BW-1:O_BW]) ? '1 : shifted_c[O_BW-1:0];
    end

    logic            v1;
    logic [O_BW-1:0] q1;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [O_BW-1:0] hold;
    logic [O_BW-1:0] rowbuf [RB_N];

    logic [BW-1:0]   idx_c;
    logic [O_BW-1:0] hmax_c;
    logic [O_BW-1:0] pool_c;
    logic            col_last_c;
    logic            row_last_c;

    always_comb begin
        idx_c      = BW'(col >> 1);
        hmax_c     = (q1 > hold) ? q1 : hold;
        pool_c     = (rowbuf[idx_c] > hmax_c) ? rowbuf[idx_c] : hmax_c;
        col_last_c = (col == CW'(IMG_W - 1));
        row_last_c = (row == RW'(IMG_H - 1));
    end

    // Stage 1 register and stage 2 pooling state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1           <= 1'b0;
            q1           <= '0;
            col          <= '0;
            row          <= '0;
            hold         <= '0;
            rowbuf       <= '{default: '0};
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            v1           <= i_valid;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_valid) begin
                q1 <= sat_c;
            end
            if (v1) begin
                if (!col[0]) begin
                    hold <= q1;
                end else if (!row[0]) begin
                    rowbuf[idx_c] <= hmax_c;
                end else begin
                    o_data       <= pool_c;
                    o_valid      <= 1'b1;
                    o_frame_done <= row_last_c && col_last_c;
                end
                // Raster position advances only on accepted samples
                if (col_last_c) begin
                    col <= '0;
                    row <= row_last_c ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule
